count_window_monitor: RTL

// - Downstream consumer of BinaryCounter: samples its count[5:0] and result outputs over programmable windows.
// - Per window, counts count wrap-arounds and result hits, then queues one record in a small FIFO.
// - Records drain to software/scoreboard logic over a valid/ready handshake.
//

---
 rtl/cwm_pkg.sv | 27 ++
 rtl/cwm_rec_fifo.sv | 50 +++++
 rtl/count_window_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cwm_pkg.sv
// Shared types for the count window monitor: FSM states, the per-window record
// and the saturating wrap increment.
package cwm_pkg;

  localparam int CNT_W  = 6;
  localparam int WIN_W  = 16;
  localparam int WRAP_W = 8;
  localparam logic [WRAP_W-1:0] WRAP_MAX = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cwm_state_e;

  typedef struct packed {
    logic [WRAP_W-1:0] wraps;
    logic [WIN_W-1:0]  hits;
    logic [CNT_W-1:0]  last_count;
    logic              partial;
  } cwm_rec_t;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v,
                                                input logic inc);
    return (inc && (v != WRAP_MAX)) ? v + WRAP_W'(1) : v;
  endfunction

endpackage

// File: rtl/cwm_rec_fifo.sv
// Record FIFO with first-word-fallthrough head. A push into a full FIFO is
// still accepted when the head is popped on the same edge.
module cwm_rec_fifo
  import cwm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clock,
  input  logic     i_reset,
  input  logic     i_push,
  input  cwm_rec_t i_data,
  input  logic     i_pop,
  output cwm_rec_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  cwm_rec_t    r_mem [DEPTH];
  logic        w_pop;
  logic        w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Fields read as zero while empty so nothing stale leaks out after reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/count_window_monitor.sv
// Samples a counter over programmable windows, counting wraps and result hits,
// and queues one record per window for a valid/ready consumer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no window open; waits for enable with a nonzero length
// ST_RUN  | window open; samples count/result every cycle
module count_window_monitor
  import cwm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [WIN_W-1:0]  i_win_len,
  input  logic [CNT_W-1:0]  i_count_in,
  input  logic              i_result_in,
  output logic              o_rec_valid,
  input  logic              i_rec_ready,
  output logic [WRAP_W-1:0] o_rec_wraps,
  output logic [WIN_W-1:0]  o_rec_hits,
  output logic [CNT_W-1:0]  o_rec_last_count,
  output logic              o_rec_partial,
  output logic              o_overflow,
  output logic              o_busy
);

  cwm_state_e        r_state;
  logic [WIN_W-1:0]  r_win_q;
  logic [WIN_W-1:0]  r_cyc;
  logic [WIN_W-1:0]  r_hits;
  logic [WRAP_W-1:0] r_wraps;
  logic [CNT_W-1:0]  r_prev_count;
  logic              r_prev_vld;
  logic              r_overflow;

  logic              w_wrap;
  logic [WRAP_W-1:0] w_wraps_nx;
  logic [WIN_W-1:0]  w_hits_nx;
  logic              w_end;
  logic              w_push;
  cwm_rec_t          w_rec;
  cwm_rec_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  assign w_wrap     = r_prev_vld && (i_count_in < r_prev_count);
  assign w_wraps_nx = sat_inc(r_wraps, w_wrap);
  assign w_hits_nx  = r_hits + {{(WIN_W-1){1'b0}}, i_result_in};
  assign w_end      = (r_state == ST_RUN) && (r_cyc == r_win_q - WIN_W'(1));
  assign w_pop      = !w_empty && i_rec_ready;

  // The final cycle of a window is always sampled; enable only decides what follows.
  always_comb begin
    w_push = 1'b0;
    w_rec  = '0;
    if (w_end) begin
      w_push = 1'b1;
      w_rec  = '{wraps: w_wraps_nx, hits: w_hits_nx,
                 last_count: i_count_in, partial: 1'b0};
    end else if ((r_state == ST_RUN) && !i_enable) begin
      w_push = 1'b1;
      w_rec  = '{wraps: r_wraps, hits: r_hits,
                 last_count: r_prev_count, partial: 1'b1};
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_win_q      <= '0;
      r_cyc        <= '0;
      r_hits       <= '0;
      r_wraps      <= '0;
      r_prev_count <= '0;
      r_prev_vld   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_prev_vld <= 1'b0;
          if (i_enable && (i_win_len != '0)) begin
            r_win_q <= i_win_len;
            r_cyc   <= '0;
            r_hits  <= '0;
            r_wraps <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_end || i_enable) begin
            r_prev_count <= i_count_in;
            r_prev_vld   <= 1'b1;
          end
          if (w_end) begin
            r_cyc   <= '0;
            r_hits  <= '0;
            r_wraps <= '0;
            // A zero length at the boundary would never terminate, so stop instead.
            if (i_enable && (i_win_len != '0)) begin
              r_win_q <= i_win_len;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!i_enable) begin
            r_state <= ST_IDLE;
          end else begin
            r_cyc   <= r_cyc + WIN_W'(1);
            r_hits  <= w_hits_nx;
            r_wraps <= w_wraps_nx;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cwm_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (i_rec_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_rec_valid      = !w_empty;
  assign o_rec_wraps      = w_head.wraps;
  assign o_rec_hits       = w_head.hits;
  assign o_rec_last_count = w_head.last_count;
  assign o_rec_partial    = w_head.partial;
  assign o_overflow       = r_overflow;
  assign o_busy           = (r_state == ST_RUN);

endmodule
